// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: one outstanding request/response transaction on the data bus.
// Optional MEM_ADDR_CHECK_EN enables alignment exceptions; otherwise misaligned low address bits are cleared.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              out_valid,
  output logic [31:0]       out_rdata,
  output logic              out_adel,
  output logic              out_ades,
  output logic [ADDR_W-1:0] out_badvaddr
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t state, state_nx;

  logic              accept;
  logic              handled, is_load, misaligned, addr_err;
  logic [1:0]        size;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;
  logic [7:0]        op_q;
  logic [1:0]        addr_lo_q;
  logic              kill_q;
  logic              resp_now;
  logic [31:0]       ld_result;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready && !flush;

  // Decode of the op being presented; only used in the accept cycle.
  always_comb begin
    handled    = 1'b0;
    is_load    = 1'b0;
    size       = 2'd0;
    misaligned = 1'b0;
    st_wdata   = '0;
    st_wstrb   = '0;
    case (in_op)
      OP_LB, OP_LBU: begin handled = 1'b1; is_load = 1'b1; end
      OP_LH, OP_LHU: begin
        handled = 1'b1; is_load = 1'b1; size = 2'd1;
        misaligned = in_addr[0];
      end
      OP_LW: begin
        handled = 1'b1; is_load = 1'b1; size = 2'd2;
        misaligned = |in_addr[1:0];
      end
      OP_SB: begin
        handled  = 1'b1;
        st_wdata = {4{in_wdata[7:0]}};
        st_wstrb = 4'b0001 << in_addr[1:0];
      end
      OP_SH: begin
        handled = 1'b1; size = 2'd1;
        misaligned = in_addr[0];
        st_wdata = {2{in_wdata[15:0]}};
        st_wstrb = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: begin
        handled = 1'b1; size = 2'd2;
        misaligned = |in_addr[1:0];
        st_wdata = in_wdata;
        st_wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

`ifdef MEM_ADDR_CHECK_EN
  assign addr_err = handled && misaligned;
  assign bus_addr = in_addr;
`else
  assign addr_err = 1'b0;
  always_comb begin
    bus_addr = in_addr;
    if (size == 2'd1) bus_addr[0]   = 1'b0;
    if (size == 2'd2) bus_addr[1:0] = 2'b00;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = (!handled || addr_err) ? S_DONE : S_REQ;
      S_REQ:  if (data_addr_ok) state_nx = data_data_ok ? S_DONE : S_WAIT;
      S_WAIT: if (data_data_ok) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign resp_now = ((state == S_REQ) && data_addr_ok && data_data_ok) ||
                    ((state == S_WAIT) && data_data_ok);

  always_comb begin
    ld_byte = data_rdata[8*addr_lo_q +: 8];
    ld_half = addr_lo_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (op_q)
      OP_LB:   ld_result = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_result = {24'd0, ld_byte};
      OP_LH:   ld_result = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_result = {16'd0, ld_half};
      OP_LW:   ld_result = data_rdata;
      default: ld_result = '0;
    endcase
  end

  // A flush after acceptance lets the bus transaction finish but marks the result dead.
  assign out_valid = (state == S_DONE) && !kill_q && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q         <= '0;
      addr_lo_q    <= '0;
      kill_q       <= 1'b0;
      data_req     <= 1'b0;
      data_wr      <= 1'b0;
      data_size    <= '0;
      data_addr    <= '0;
      data_wdata   <= '0;
      data_wstrb   <= '0;
      out_rdata    <= '0;
      out_adel     <= 1'b0;
      out_ades     <= 1'b0;
      out_badvaddr <= '0;
    end else begin
      if (accept) begin
        op_q      <= in_op;
        addr_lo_q <= in_addr[1:0];
        kill_q    <= 1'b0;
        out_adel  <= addr_err && is_load;
        out_ades  <= addr_err && !is_load;
        if (handled && !addr_err) begin
          data_req   <= 1'b1;
          data_wr    <= !is_load;
          data_size  <= size;
          data_addr  <= bus_addr;
          data_wdata <= st_wdata;
          data_wstrb <= st_wstrb;
        end else begin
          out_rdata <= '0;
          if (addr_err) out_badvaddr <= in_addr;
        end
      end
      if ((state == S_REQ) && data_addr_ok) data_req <= 1'b0;
      if (((state == S_REQ) || (state == S_WAIT)) && flush) kill_q <= 1'b1;
      if (resp_now) out_rdata <= ld_result;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; the bus agent is driven step by step.
// Honours MEM_ADDR_CHECK_EN to select the expected misaligned-access behaviour.
module tb_mem_access_ctrl;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        flush;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic        out_adel, out_ades;
  logic [31:0] out_badvaddr;

  int checks = 0;
  int fails  = 0;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .out_valid(out_valid), .out_rdata(out_rdata),
    .out_adel(out_adel), .out_ades(out_ades), .out_badvaddr(out_badvaddr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd;
    step();
    in_valid = 1'b0;
  endtask

  task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
    data_addr_ok = aok; data_data_ok = dok; data_rdata = rd;
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0;
    flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_data_req", {31'd0, data_req}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data_addr", data_addr, 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    step(); step();
    resetn = 1'b1;
    step();

    // LB at 0x1003, single-cycle bus response
    issue(OP_LB, 32'h1003, 32'h0);
    chk("lb_req", {31'd0, data_req}, 32'd1);
    chk("lb_size", {30'd0, data_size}, 32'd0);
    chk("lb_wr", {31'd0, data_wr}, 32'd0);
    chk("lb_wstrb", {28'd0, data_wstrb}, 32'd0);
    chk("lb_addr", data_addr, 32'h1003);
    chk("lb_ready_busy", {31'd0, in_ready}, 32'd0);
    bus(1'b1, 1'b1, 32'h80FF_1234);
    step();
    bus(1'b0, 1'b0, 32'h0);
    chk("lb_valid", {31'd0, out_valid}, 32'd1);
    chk("lb_rdata", out_rdata, 32'hFFFF_FF80);
    chk("lb_req_drop", {31'd0, data_req}, 32'd0);
    step();
    chk("lb_valid_pulse", {31'd0, out_valid}, 32'd0);
    chk("lb_ready_back", {31'd0, in_ready}, 32'd1);

    // SH at 0x2002 with addr_ok held off three cycles
    issue(OP_SH, 32'h2002, 32'h0000_ABCD);
    for (int i = 0; i < 3; i++) begin
      chk("sh_req_held", {31'd0, data_req}, 32'd1);
      chk("sh_wstrb", {28'd0, data_wstrb}, 32'hC);
      chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
      chk("sh_wr", {31'd0, data_wr}, 32'd1);
      chk("sh_addr", data_addr, 32'h2002);
      chk("sh_size", {30'd0, data_size}, 32'd1);
      step();
    end
    chk("sh_req_4th", {31'd0, data_req}, 32'd1);
    bus(1'b1, 1'b1, 32'hFFFF_FFFF);
    step();
    bus(1'b0, 1'b0, 32'h0);
    chk("sh_valid", {31'd0, out_valid}, 32'd1);
    chk("sh_rdata_zero", out_rdata, 32'd0);
    step();

    // SB at 0x0001: byte lane 1
    issue(OP_SB, 32'h0000_0001, 32'h1234_56A5);
    chk("sb_wstrb", {28'd0, data_wstrb}, 32'h2);
    chk("sb_wdata", data_wdata, 32'hA5A5_A5A5);
    bus(1'b1, 1'b1, 32'h0);
    step();
    bus(1'b0, 1'b0, 32'h0);
    chk("sb_valid", {31'd0, out_valid}, 32'd1);
    step();

    // LHU at 0x10 with a split response
    issue(OP_LHU, 32'h10, 32'h0);
    chk("lhu_size", {30'd0, data_size}, 32'd1);
    bus(1'b1, 1'b0, 32'h0);
    step();
    bus(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("lhu_ready_low", {31'd0, in_ready}, 32'd0);
      chk("lhu_wait_noreq", {31'd0, data_req}, 32'd0);
      chk("lhu_wait_novalid", {31'd0, out_valid}, 32'd0);
      step();
    end
    bus(1'b0, 1'b1, 32'h0000_9ABC);
    chk("lhu_ready_low_last", {31'd0, in_ready}, 32'd0);
    step();
    bus(1'b0, 1'b0, 32'h0);
    chk("lhu_valid", {31'd0, out_valid}, 32'd1);
    chk("lhu_rdata", out_rdata, 32'h0000_9ABC);
    step();

    // LH at 0x2 picks the upper half and sign-extends
    issue(OP_LH, 32'h2, 32'h0);
    bus(1'b1, 1'b1, 32'h8001_7FFF);
    step();
    bus(1'b0, 1'b0, 32'h0);
    chk("lh_rdata", out_rdata, 32'hFFFF_8001);
    step();

    // Unhandled op code completes without bus activity
    issue(8'h00, 32'h4000, 32'h0);
    chk("unh_noreq", {31'd0, data_req}, 32'd0);
    chk("unh_valid", {31'd0, out_valid}, 32'd1);
    chk("unh_rdata", out_rdata, 32'd0);
    step();

    // Misaligned LW at 0x1002
    issue(OP_LW, 32'h1002, 32'h0);
`ifdef MEM_ADDR_CHECK_EN
    chk("lwmis_noreq", {31'd0, data_req}, 32'd0);
    chk("lwmis_valid", {31'd0, out_valid}, 32'd1);
    chk("lwmis_adel", {31'd0, out_adel}, 32'd1);
    chk("lwmis_ades", {31'd0, out_ades}, 32'd0);
    chk("lwmis_badv", out_badvaddr, 32'h1002);
    step();
`else
    chk("lwmis_req", {31'd0, data_req}, 32'd1);
    chk("lwmis_addr", data_addr, 32'h1000);
    chk("lwmis_size", {30'd0, data_size}, 32'd2);
    bus(1'b1, 1'b1, 32'h1122_3344);
    step();
    bus(1'b0, 1'b0, 32'h0);
    chk("lwmis_valid", {31'd0, out_valid}, 32'd1);
    chk("lwmis_rdata", out_rdata, 32'h1122_3344);
    chk("lwmis_adel", {31'd0, out_adel}, 32'd0);
    step();
`endif

    // Flush while presenting in IDLE: op not accepted
    in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h40; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flidle_ready", {31'd0, in_ready}, 32'd1);
    chk("flidle_noreq", {31'd0, data_req}, 32'd0);

    // Flush in WAIT: bus completes, no out_valid
    issue(OP_LB, 32'h5, 32'h0);
    bus(1'b1, 1'b0, 32'h0);
    step();
    bus(1'b0, 1'b0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flwait_busy", {31'd0, in_ready}, 32'd0);
    bus(1'b0, 1'b1, 32'h0000_7700);
    step();
    bus(1'b0, 1'b0, 32'h0);
    chk("flwait_novalid", {31'd0, out_valid}, 32'd0);
    step();
    chk("flwait_ready", {31'd0, in_ready}, 32'd1);
    issue(OP_LW, 32'h20, 32'h0);
    chk("post_fl_addr", data_addr, 32'h20);
    bus(1'b1, 1'b1, 32'hDEAD_BEEF);
    step();
    bus(1'b0, 1'b0, 32'h0);
    chk("post_fl_valid", {31'd0, out_valid}, 32'd1);
    chk("post_fl_rdata", out_rdata, 32'hDEAD_BEEF);
    step();

    // Reset asserted in WAIT
    issue(OP_SH, 32'h30, 32'h0000_1111);
    bus(1'b1, 1'b0, 32'h0);
    step();
    bus(1'b0, 1'b0, 32'h0);
    resetn = 1'b0;
    #1;
    chk("rstw_req", {31'd0, data_req}, 32'd0);
    chk("rstw_wr", {31'd0, data_wr}, 32'd0);
    chk("rstw_addr", data_addr, 32'd0);
    chk("rstw_wdata", data_wdata, 32'd0);
    chk("rstw_wstrb", {28'd0, data_wstrb}, 32'd0);
    chk("rstw_rdata", out_rdata, 32'd0);
    chk("rstw_valid", {31'd0, out_valid}, 32'd0);
    step();
    resetn = 1'b1;
    step();
    chk("rstw_ready", {31'd0, in_ready}, 32'd1);
    bus(1'b0, 1'b1, 32'h5555_5555);
    step();
    bus(1'b0, 1'b0, 32'h0);
    chk("stray_dok_1", {31'd0, out_valid}, 32'd0);
    step();
    chk("stray_dok_2", {31'd0, out_valid}, 32'd0);
    chk("stray_ready", {31'd0, in_ready}, 32'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
